// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int         WORD_BYTES        = 4;

endpackage

// File: rtl/word_assembler.sv
// Big-endian 8-to-32 shift register; word_full marks the byte that completes a word.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_full
);

  // Only the three older bytes need storage; the fourth is the live input byte.
  logic [23:0] shreg;
  logic [1:0]  count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shreg <= '0;
      count <= '0;
    end else if (shift) begin
      shreg <= {shreg[15:0], din};
      count <= count + 2'd1;
    end
  end

  assign word      = {shreg, din};
  assign word_full = shift && (count == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/program_loader.sv
// Frames a byte stream into instruction words, writes them to program memory and
// releases the core only after the whole image passes its XOR checksum.
module program_loader
  import loader_pkg::*;
#(
  parameter int          MEMORY_DEPTH = 32,
  parameter logic [31:0] BASE_ADDR    = 32'h0040_0000,
  parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  state_t      state;
  logic [15:0] word_count;
  logic [15:0] index;
  logic [7:0]  checksum;

  logic        accept;
  logic        restart_load;
  logic [15:0] len_full;
  logic        len_too_big;
  logic [15:0] index_inc;
  logic [31:0] asm_word;
  logic        asm_full;

  assign accept       = byte_valid && byte_ready;
  assign restart_load = accept && (byte_data == SYNC_BYTE) &&
                        (state == IDLE || state == DONE || state == ERROR);
  assign len_full     = {word_count[15:8], byte_data};
  assign len_too_big  = len_full > 16'(MEMORY_DEPTH);
  assign index_inc    = index + 16'd1;

  word_assembler u_word_assembler (
    .clk       (clk),
    .reset     (reset),
    .clear     (restart_load),
    .shift     (accept && state == DATA),
    .din       (byte_data),
    .word      (asm_word),
    .word_full (asm_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
      index      <= '0;
      checksum   <= '0;
    end else begin
      byte_ready <= 1'b1;
      case (state)
        IDLE, DONE, ERROR: begin
          if (restart_load) begin
            state    <= LEN_HI;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            checksum <= '0;
            index    <= '0;
          end
        end
        LEN_HI: begin
          if (accept) begin
            word_count[15:8] <= byte_data;
            state            <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            word_count[7:0] <= byte_data;
            if (len_too_big) begin
              state <= ERROR;
              error <= 1'b1;
            end else if (len_full == 16'd0) begin
              state <= CHECK;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            checksum <= checksum ^ byte_data;
            if (asm_full) begin
              state      <= WRITE;
              mem_we     <= 1'b1;
              mem_addr   <= BASE_ADDR + {14'd0, index, 2'b00};
              mem_wdata  <= asm_word;
              byte_ready <= 1'b0;
            end
          end
        end
        WRITE: begin
          // Address and data stay put until the memory takes the write.
          if (mem_ack) begin
            mem_we <= 1'b0;
            index  <= index_inc;
            state  <= (index_inc == word_count) ? CHECK : DATA;
          end else begin
            byte_ready <= 1'b0;
          end
        end
        CHECK: begin
          if (accept) begin
            if (byte_data == checksum) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed frames for program_loader; expected writes are queued and checked by a monitor.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        cpu_hold;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  program_loader dut (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  stim[$];
  int          checks = 0;
  int          errors = 0;
  int          ack_delay = 0;
  int          we_cnt = 0;
  logic [31:0] prev_addr;
  logic [31:0] prev_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: drives mem_ack and scores every accepted write against the queue.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      chk("byte_ready_low_in_write", 32'(byte_ready), 32'd0);
      if (we_cnt > 0) begin
        chk("addr_stable", mem_addr, prev_addr);
        chk("data_stable", mem_wdata, prev_data);
      end
      prev_addr = mem_addr;
      prev_data = mem_wdata;
      mem_ack   = (we_cnt >= ack_delay);
      we_cnt++;
      if (mem_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %h data %h required none", mem_addr, mem_wdata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("write_addr", mem_addr, e.addr);
          chk("write_data", mem_wdata, e.data);
          $display("write addr=%h data=%h", mem_addr, mem_wdata);
        end
      end
    end else begin
      we_cnt  = 0;
      mem_ack = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (byte_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: byte %h not accepted within 50 cycles", b);
    end
    @(posedge clk);
  endtask

  task automatic send_stim();
    foreach (stim[i]) send_byte(stim[i]);
    stim.delete();
  endtask

  task automatic go_idle(input int cycles);
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic h);
    chk({tag, "_done"}, 32'(done), 32'(d));
    chk({tag, "_error"}, 32'(error), 32'(e));
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(h));
    $display("frame %s: done=%0b error=%0b cpu_hold=%0b", tag, done, error, cpu_hold);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0040_0000);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 32'(byte_ready), 32'd1);

    // Two-word image with leading junk bytes, ack always granted.
    exp_q.push_back('{addr: 32'h0040_0000, data: 32'h2008_0005});
    exp_q.push_back('{addr: 32'h0040_0004, data: 32'h2109_0003});
    stim = '{8'h3C, 8'h11, 8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
             8'h21, 8'h09, 8'h00, 8'h03, 8'h06};
    send_stim();
    #1;
    check_status("good", 1'b1, 1'b0, 1'b0);
    chk("good_q_empty", 32'(exp_q.size()), 32'd0);
    go_idle(2);

    // Same image with a bad checksum: writes still happen, frame rejected.
    exp_q.push_back('{addr: 32'h0040_0000, data: 32'h2008_0005});
    exp_q.push_back('{addr: 32'h0040_0004, data: 32'h2109_0003});
    stim = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
             8'h21, 8'h09, 8'h00, 8'h03, 8'h07};
    send_stim();
    #1;
    check_status("badsum", 1'b0, 1'b1, 1'b1);
    chk("badsum_q_empty", 32'(exp_q.size()), 32'd0);
    go_idle(2);

    // Oversized word count is rejected straight after the length field.
    stim = '{8'hA5, 8'h00, 8'h21};
    send_stim();
    #1;
    check_status("toolong", 1'b0, 1'b1, 1'b1);
    go_idle(5);
    chk("toolong_no_we", 32'(mem_we), 32'd0);

    // Slow memory with byte_valid held high across the stalled write.
    ack_delay = 3;
    exp_q.push_back('{addr: 32'h0040_0000, data: 32'hDEAD_BEEF});
    stim = '{8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    send_stim();
    #1;
    check_status("slowack", 1'b1, 1'b0, 1'b0);
    chk("slowack_q_empty", 32'(exp_q.size()), 32'd0);
    go_idle(2);
    ack_delay = 0;

    // Reset part way through a word discards it.
    stim = '{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22};
    send_stim();
    @(negedge clk);
    byte_valid = 1'b0;
    reset      = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("midreset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_ready", 32'(byte_ready), 32'd1);
    exp_q.push_back('{addr: 32'h0040_0000, data: 32'h1234_5678});
    stim = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    send_stim();
    #1;
    check_status("reload", 1'b1, 1'b0, 1'b0);
    chk("reload_q_empty", 32'(exp_q.size()), 32'd0);
    go_idle(2);

    // Empty image, then a new sync re-holds the core.
    stim = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_stim();
    #1;
    check_status("empty", 1'b1, 1'b0, 1'b0);
    send_byte(8'hA5);
    #1;
    check_status("resync", 1'b0, 1'b0, 1'b1);
    go_idle(5);
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
